// File: rtl/turn_input_conditioner.sv
// Debounces the two active-low turn keys and buffers one turn request,
// released as a single-cycle right_P/left_P pulse aligned with game_tik.
module turn_input_conditioner #(
    parameter int DEBOUNCE_CYCLES = 250000,
    parameter int CNT_BIT         = 18
) (
    input  logic       clock_25,
    input  logic       reset,
    input  logic       key_right_n,
    input  logic       key_left_n,
    input  logic       game_tik,
    output logic       right_P,
    output logic       left_P,
    output logic       turn_pending,
    output logic [1:0] state_dbg
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        PEND_R = 2'd1,
        PEND_L = 2'd2
    } state_t;

    localparam logic [CNT_BIT-1:0] CNT_MAX = CNT_BIT'(DEBOUNCE_CYCLES - 1);

    // Index 0 is the right key, index 1 the left key.
    logic [1:0]         keys_n;
    logic [1:0]         sync1;
    logic [1:0]         sync2;
    logic [1:0]         stable;
    logic [1:0]         press;
    logic [CNT_BIT-1:0] cnt [2];

    assign keys_n = {key_left_n, key_right_n};

    for (genvar k = 0; k < 2; k++) begin : g_key
        // A press is the accepted 1->0 flip of the debounced level.
        assign press[k] = (sync2[k] != stable[k]) && (cnt[k] == CNT_MAX) && stable[k];

        always_ff @(posedge clock_25) begin
            if (reset) begin
                sync1[k]  <= 1'b1;
                sync2[k]  <= 1'b1;
                stable[k] <= 1'b1;
                cnt[k]    <= '0;
            end else begin
                sync1[k] <= keys_n[k];
                sync2[k] <= sync1[k];
                if (sync2[k] == stable[k]) begin
                    cnt[k] <= '0;
                end else if (cnt[k] == CNT_MAX) begin
                    stable[k] <= sync2[k];
                    cnt[k]    <= '0;
                end else begin
                    cnt[k] <= cnt[k] + 1'b1;
                end
            end
        end
    end

    state_t state;
    state_t state_next;

    always_ff @(posedge clock_25) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // A tick consumes the pending turn; a single-key press in the same cycle
    // becomes the new pending turn. Simultaneous presses are ambiguous and dropped.
    always_comb begin
        state_next = state;
        if (game_tik && (state != IDLE)) begin
            state_next = IDLE;
        end
        if (press[0] && !press[1]) begin
            state_next = PEND_R;
        end else if (press[1] && !press[0]) begin
            state_next = PEND_L;
        end
    end

    assign right_P      = (state == PEND_R) && game_tik;
    assign left_P       = (state == PEND_L) && game_tik;
    assign turn_pending = (state != IDLE);
    assign state_dbg    = state;

endmodule

// File: tb/tb_turn_input_conditioner.sv
// Directed bench for turn_input_conditioner with DEBOUNCE_CYCLES=4, CNT_BIT=3.
module tb_turn_input_conditioner;

    localparam int DC = 4;
    localparam logic [1:0] S_IDLE = 2'd0, S_PEND_R = 2'd1, S_PEND_L = 2'd2;

    logic       clock_25 = 1'b0;
    logic       reset = 1'b1;
    logic       key_right_n = 1'b1;
    logic       key_left_n = 1'b1;
    logic       game_tik = 1'b0;
    logic       right_P;
    logic       left_P;
    logic       turn_pending;
    logic [1:0] state_dbg;

    int errors = 0;
    int checks = 0;

    turn_input_conditioner #(.DEBOUNCE_CYCLES(DC), .CNT_BIT(3)) dut (
        .clock_25    (clock_25),
        .reset       (reset),
        .key_right_n (key_right_n),
        .key_left_n  (key_left_n),
        .game_tik    (game_tik),
        .right_P     (right_P),
        .left_P      (left_P),
        .turn_pending(turn_pending),
        .state_dbg   (state_dbg)
    );

    always #5 clock_25 = ~clock_25;

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clock_25);
            #1;
        end
    endtask

    // One-cycle game_tik; returns the pulse outputs seen during that cycle.
    task automatic pulse_tik(output logic rp, output logic lp);
        game_tik = 1'b1;
        #1;
        rp = right_P;
        lp = left_P;
        tick(1);
        game_tik = 1'b0;
    endtask

    // Hold the chosen key(s) low long enough to be accepted, then let go and
    // wait until the release has been debounced too.
    task automatic press_release(input logic r, input logic l, input int hold);
        key_right_n = ~r;
        key_left_n  = ~l;
        tick(hold);
        key_right_n = 1'b1;
        key_left_n  = 1'b1;
        tick(DC + 2);
    endtask

    task automatic test_reset();
        logic bad;
        bad = 1'b0;
        reset = 1'b1;
        for (int i = 0; i < 6; i++) begin
            game_tik = i[0];
            #1;
            if ({right_P, left_P, turn_pending} !== 3'b000) bad = 1'b1;
            tick(1);
        end
        game_tik = 1'b0;
        checks++;
        if (bad !== 1'b0) begin
            errors++;
            $display("FAIL reset_outputs: got nonzero output during reset, expected 0");
        end
        checks++;
        if (state_dbg !== S_IDLE) begin
            errors++;
            $display("FAIL reset_state: got %0d expected %0d", state_dbg, S_IDLE);
        end
        reset = 1'b0;
        bad = 1'b0;
        for (int i = 0; i < 20; i++) begin
            game_tik = (i % 5 == 4);
            #1;
            if ({right_P, left_P, turn_pending} !== 3'b000) bad = 1'b1;
            tick(1);
        end
        game_tik = 1'b0;
        checks++;
        if (bad !== 1'b0) begin
            errors++;
            $display("FAIL idle_outputs: got nonzero output with keys released, expected 0");
        end
    endtask

    task automatic test_glitch_and_press();
        logic bad, rp, lp;
        bad = 1'b0;
        key_right_n = 1'b0;
        tick(3);
        key_right_n = 1'b1;
        for (int i = 0; i < 10; i++) begin
            if (turn_pending !== 1'b0) bad = 1'b1;
            tick(1);
        end
        checks++;
        if (bad !== 1'b0) begin
            errors++;
            $display("FAIL glitch_reject: turn_pending rose after 3-cycle glitch, expected 0");
        end
        key_right_n = 1'b0;
        tick(DC + 1);
        checks++;
        if (turn_pending !== 1'b0) begin
            errors++;
            $display("FAIL press_latency_early: got %b after edge %0d expected 0", turn_pending, DC + 1);
        end
        tick(1);
        checks++;
        if (turn_pending !== 1'b1 || state_dbg !== S_PEND_R) begin
            errors++;
            $display("FAIL press_latency: got pending=%b state=%0d after edge %0d expected 1/%0d",
                     turn_pending, state_dbg, DC + 2, S_PEND_R);
        end
        tick(4);
        key_right_n = 1'b1;
        tick(DC + 2);
        checks++;
        if (turn_pending !== 1'b1) begin
            errors++;
            $display("FAIL release_no_event: got pending=%b expected 1", turn_pending);
        end
        pulse_tik(rp, lp);
        checks++;
        if ({rp, lp} !== 2'b10) begin
            errors++;
            $display("FAIL right_pulse: got r=%b l=%b expected r=1 l=0", rp, lp);
        end
        checks++;
        if (turn_pending !== 1'b0 || right_P !== 1'b0) begin
            errors++;
            $display("FAIL pulse_clear: got pending=%b right_P=%b expected 0/0", turn_pending, right_P);
        end
    endtask

    task automatic test_overwrite();
        logic rp, lp;
        press_release(1'b1, 1'b0, DC + 2);
        press_release(1'b0, 1'b1, DC + 2);
        checks++;
        if (state_dbg !== S_PEND_L) begin
            errors++;
            $display("FAIL overwrite_state: got %0d expected %0d", state_dbg, S_PEND_L);
        end
        pulse_tik(rp, lp);
        checks++;
        if ({rp, lp} !== 2'b01) begin
            errors++;
            $display("FAIL overwrite_pulse: got r=%b l=%b expected r=0 l=1", rp, lp);
        end
    endtask

    task automatic test_held_key();
        logic rp, lp;
        logic [2:0] seen;
        key_left_n = 1'b0;
        tick(DC + 2);
        for (int i = 0; i < 3; i++) begin
            pulse_tik(rp, lp);
            seen[i] = lp;
            if (rp !== 1'b0) seen[i] = 1'bx;
            tick(3);
        end
        key_left_n = 1'b1;
        tick(DC + 2);
        checks++;
        if (seen !== 3'b001) begin
            errors++;
            $display("FAIL held_one_pulse: got left pulses %b (tik2..tik0) expected 001", seen);
        end
        checks++;
        if (turn_pending !== 1'b0) begin
            errors++;
            $display("FAIL held_release_idle: got pending=%b expected 0", turn_pending);
        end
    endtask

    task automatic test_back_to_back();
        logic bad, rp, lp;
        bad = 1'b0;
        key_right_n = 1'b0;
        key_left_n  = 1'b0;
        for (int i = 0; i < 10; i++) begin
            game_tik = (i == 7);
            #1;
            if ({right_P, left_P, turn_pending} !== 3'b000 || state_dbg !== S_IDLE) bad = 1'b1;
            tick(1);
        end
        game_tik = 1'b0;
        key_right_n = 1'b1;
        key_left_n  = 1'b1;
        tick(DC + 2);
        checks++;
        if (bad !== 1'b0 || turn_pending !== 1'b0) begin
            errors++;
            $display("FAIL both_keys_dropped: got a state change or pulse, expected none");
        end
        press_release(1'b0, 1'b1, DC + 2);
        key_right_n = 1'b0;
        tick(DC + 1);
        pulse_tik(rp, lp);
        checks++;
        if ({rp, lp} !== 2'b01) begin
            errors++;
            $display("FAIL tik_with_press_pulse: got r=%b l=%b expected r=0 l=1", rp, lp);
        end
        checks++;
        if (state_dbg !== S_PEND_R || turn_pending !== 1'b1) begin
            errors++;
            $display("FAIL tik_with_press_state: got state=%0d pending=%b expected %0d/1",
                     state_dbg, turn_pending, S_PEND_R);
        end
        key_right_n = 1'b1;
        tick(DC + 2);
        pulse_tik(rp, lp);
        checks++;
        if ({rp, lp} !== 2'b10) begin
            errors++;
            $display("FAIL tik_with_press_followup: got r=%b l=%b expected r=1 l=0", rp, lp);
        end
    endtask

    task automatic test_reset_mid();
        logic rp, lp;
        press_release(1'b1, 1'b0, DC + 2);
        reset = 1'b1;
        tick(1);
        reset = 1'b0;
        checks++;
        if (turn_pending !== 1'b0) begin
            errors++;
            $display("FAIL mid_reset_clear: got pending=%b expected 0", turn_pending);
        end
        pulse_tik(rp, lp);
        checks++;
        if ({rp, lp, turn_pending} !== 3'b000) begin
            errors++;
            $display("FAIL mid_reset_tik: got r=%b l=%b pending=%b expected 0/0/0", rp, lp, turn_pending);
        end
        key_right_n = 1'b0;
        tick(DC + 2);
        reset = 1'b1;
        tick(1);
        reset = 1'b0;
        tick(DC + 1);
        checks++;
        if (turn_pending !== 1'b0) begin
            errors++;
            $display("FAIL held_reset_early: got pending=%b expected 0", turn_pending);
        end
        tick(1);
        checks++;
        if (turn_pending !== 1'b1 || state_dbg !== S_PEND_R) begin
            errors++;
            $display("FAIL held_reset_reaccept: got pending=%b state=%0d expected 1/%0d",
                     turn_pending, state_dbg, S_PEND_R);
        end
        key_right_n = 1'b1;
        tick(DC + 2);
        pulse_tik(rp, lp);
    endtask

    initial begin
        tick(1);
        test_reset();
        test_glitch_and_press();
        test_overwrite();
        test_held_key();
        test_back_to_back();
        test_reset_mid();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
